hsync_generator: RTL and testbench

HSYNC_GENERATOR -- requirements
Module: hsync_generator

---
 rtl/hsync_generator_if.sv | 34 +++
 rtl/hsync_generator.sv | 92 +++++++++
 tb/tb_hsync_generator.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/hsync_generator_if.sv
// rtl/hsync_generator_if.sv - horizontal timing configuration and status bundle
//
// Purpose: groups the horizontal segment lengths (driven by the timing
// master) and the pixel-rate/position/sync outputs (driven by the generator).
// Ports:
//   ActiveVideo, FrontPorch, SynchPulse, BackPorch : segment lengths in pixels
//   PixelTick : one-CLK pixel-rate enable
//   xposition : current pixel column
//   hsync     : active-low horizontal sync
//   ActiveX   : high while xposition is inside the active-video segment
//   LineEnd   : one-CLK end-of-line pulse for the vertical timer
interface hsync_generator_if #(
  parameter int xresolution = 10
);
  logic [xresolution-1:0] ActiveVideo;
  logic [xresolution-1:0] FrontPorch;
  logic [xresolution-1:0] SynchPulse;
  logic [xresolution-1:0] BackPorch;
  logic                   PixelTick;
  logic [xresolution-1:0] xposition;
  logic                   hsync;
  logic                   ActiveX;
  logic                   LineEnd;

  modport master (
    output ActiveVideo, FrontPorch, SynchPulse, BackPorch,
    input  PixelTick, xposition, hsync, ActiveX, LineEnd
  );

  modport slave (
    input  ActiveVideo, FrontPorch, SynchPulse, BackPorch,
    output PixelTick, xposition, hsync, ActiveX, LineEnd
  );
endinterface

// File: rtl/hsync_generator.sv
// rtl/hsync_generator.sv - horizontal video timing generator with pixel divider
//
// Purpose: divides CLK down to a pixel rate, walks xcount across a line made of
// Active, FrontPorch, SynchPulse and BackPorch segments, and decodes hsync,
// ActiveX and a one-cycle LineEnd pulse. Segment lengths are captured into
// shadow registers at line wrap so mid-line input changes affect the next line.
// Ports:
//   CLK   : system clock, rising edge
//   RESET : synchronous active-low reset
//   tif   : hsync_generator_if slave (segment lengths in, timing outputs out)
module hsync_generator #(
  parameter int xresolution = 10,
  parameter int PixelDivide = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  hsync_generator_if.slave  tif
);
  localparam int XW = xresolution;
  // Two guard bits: the four-way sum of XW-bit values never overflows SW bits.
  localparam int SW = xresolution + 2;
  localparam logic [7:0]    DivLast  = 8'(PixelDivide - 1);
  localparam logic [SW-1:0] TotalMax = {1'b0, 1'b1, {XW{1'b0}}};

  logic [7:0]    divcount_q, divcount_d;
  logic [XW-1:0] xcount_q, xcount_d;
  logic          line_end_q, line_end_d;
  logic [XW-1:0] act_q, fp_q, sp_q, bp_q;

  logic          pixel_tick;
  logic          advance;
  logic          wrap;
  logic [SW-1:0] sum_all;
  logic [SW-1:0] total;
  logic [SW-1:0] x_ext;
  logic [SW-1:0] sync_start;
  logic [SW-1:0] sync_stop;
  logic          sync_low;

  always_comb begin
    sum_all    = SW'(act_q) + SW'(fp_q) + SW'(sp_q) + SW'(bp_q);
    total      = (sum_all > TotalMax) ? TotalMax : sum_all;
    x_ext      = SW'(xcount_q);
    sync_start = SW'(act_q) + SW'(fp_q);
    sync_stop  = sync_start + SW'(sp_q);
    sync_low   = (x_ext >= sync_start) && (x_ext < sync_stop);
    pixel_tick = (divcount_q == DivLast);
    // A zero-length line never advances, so it can never wrap either.
    advance    = pixel_tick && (total != '0);
    wrap       = advance && (x_ext == total - SW'(1));
  end

  always_comb begin
    divcount_d = pixel_tick ? 8'd0 : divcount_q + 8'd1;
    xcount_d   = xcount_q;
    if (advance) begin
      xcount_d = wrap ? '0 : xcount_q + XW'(1);
    end
    line_end_d = wrap;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      divcount_q <= '0;
      xcount_q   <= '0;
      line_end_q <= 1'b0;
    end else begin
      divcount_q <= divcount_d;
      xcount_q   <= xcount_d;
      line_end_q <= line_end_d;
    end
  end

  // Shadows track the inputs throughout reset so the first line after
  // release already uses the programmed lengths.
  always_ff @(posedge CLK) begin
    if (!RESET || wrap) begin
      act_q <= tif.ActiveVideo;
      fp_q  <= tif.FrontPorch;
      sp_q  <= tif.SynchPulse;
      bp_q  <= tif.BackPorch;
    end
  end

  assign tif.PixelTick = pixel_tick;
  assign tif.xposition = xcount_q;
  assign tif.LineEnd   = line_end_q;
  // During reset the shadows lag the inputs by a cycle, so the reset values of
  // hsync and ActiveX are forced here rather than decoded.
  assign tif.hsync     = !RESET || !sync_low;
  assign tif.ActiveX   = RESET ? (x_ext < SW'(act_q)) : (tif.ActiveVideo != '0);
endmodule

// File: tb/tb_hsync_generator.sv
// tb/tb_hsync_generator.sv - self-checking bench for hsync_generator
module tb_hsync_generator;
  localparam int XR = 10;
  localparam int P  = 4;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;

  hsync_generator_if #(.xresolution(XR)) tif ();

  hsync_generator #(.xresolution(XR), .PixelDivide(P)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .tif   (tif)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: pixel count since release and the pixel index at which
  // the current line began; xposition is simply their difference.
  int m_edges, m_pix, m_base, m_a, m_f, m_s, m_b, m_tot;
  bit m_le, m_tick;
  bit model_ok = 1'b0;

  always @(posedge CLK) begin
    cyc++;
    if (!RESET) begin
      m_edges = 0;
      m_pix   = 0;
      m_base  = 0;
      m_le    = 1'b0;
      m_a = int'(tif.ActiveVideo);
      m_f = int'(tif.FrontPorch);
      m_s = int'(tif.SynchPulse);
      m_b = int'(tif.BackPorch);
    end else begin
      m_tick = ((m_edges % P) == P - 1);
      m_edges++;
      m_le  = 1'b0;
      m_tot = m_a + m_f + m_s + m_b;
      if (m_tot > (1 << XR)) m_tot = 1 << XR;
      if (m_tick && m_tot > 0) begin
        m_pix++;
        if (m_pix - m_base == m_tot) begin
          m_base = m_pix;
          m_le   = 1'b1;
          m_a = int'(tif.ActiveVideo);
          m_f = int'(tif.FrontPorch);
          m_s = int'(tif.SynchPulse);
          m_b = int'(tif.BackPorch);
        end
      end
    end
    model_ok = 1'b1;
  end

  always @(negedge CLK) begin
    if (model_ok) begin
      int x;
      x = m_pix - m_base;
      chk("PixelTick", tif.PixelTick, (m_edges % P) == P - 1);
      chk("xposition", tif.xposition, x);
      chk("LineEnd", tif.LineEnd, m_le);
      chk("hsync", tif.hsync, !RESET ? 1 : !(x >= m_a + m_f && x < m_a + m_f + m_s));
      chk("ActiveX", tif.ActiveX, !RESET ? (tif.ActiveVideo != 0) : (x < m_a));
    end
  end

  task automatic set_seg(input int a, input int f, input int s, input int b);
    tif.ActiveVideo = XR'(a);
    tif.FrontPorch  = XR'(f);
    tif.SynchPulse  = XR'(s);
    tif.BackPorch   = XR'(b);
  endtask

  task automatic wait_x(input int target);
    for (int i = 0; i < 5000; i++) begin
      @(negedge CLK);
      if (int'(tif.xposition) == target) return;
    end
    chk("wait_x_timeout", 0, 1);
  endtask

  task automatic wait_le(output int c, output int lo_min, output int lo_max);
    lo_min = 99999;
    lo_max = -1;
    c = -1;
    for (int i = 0; i < 10000; i++) begin
      @(negedge CLK);
      if (!tif.hsync) begin
        if (int'(tif.xposition) < lo_min) lo_min = int'(tif.xposition);
        if (int'(tif.xposition) > lo_max) lo_max = int'(tif.xposition);
      end
      if (tif.LineEnd) begin
        c = cyc;
        return;
      end
    end
    chk("wait_le_timeout", 0, 1);
  endtask

  initial begin
    int le_cnt, le_at, le_x, low_cnt, fall_x, rise_x, ax_fall_x, xp;
    bit prev_h, prev_ax;
    int c0, c1, c2, lmin, lmax, first_tick;
    int bad_x, bad_h, bad_ax, bad_le, ticks, last_tick, bad_per;

    set_seg(640, 16, 96, 48);
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_xposition", tif.xposition, 0);
    chk("rst_hsync", tif.hsync, 1);
    chk("rst_ActiveX", tif.ActiveX, 1);
    chk("rst_LineEnd", tif.LineEnd, 0);
    chk("rst_PixelTick", tif.PixelTick, 0);
    #1 RESET = 1'b1;

    le_cnt = 0; le_at = -1; le_x = -1; low_cnt = 0;
    fall_x = -1; rise_x = -1; ax_fall_x = -1; first_tick = -1;
    prev_h = 1'b1; prev_ax = 1'b1;
    for (int k = 1; k <= 3200; k++) begin
      @(negedge CLK);
      xp = int'(tif.xposition);
      if (tif.PixelTick && first_tick < 0) first_tick = k;
      if (tif.LineEnd) begin le_cnt++; le_at = k; le_x = xp; end
      if (!tif.hsync) low_cnt++;
      if (prev_h && !tif.hsync && fall_x < 0) fall_x = xp;
      if (!prev_h && tif.hsync && rise_x < 0) rise_x = xp;
      if (prev_ax && !tif.ActiveX && ax_fall_x < 0) ax_fall_x = xp;
      prev_h = tif.hsync;
      prev_ax = tif.ActiveX;
    end
    c0 = cyc;
    chk("first_tick_after_release", first_tick, P - 1);
    chk("line1_le_count", le_cnt, 1);
    chk("line1_le_cycle", le_at, 3200);
    chk("line1_le_xpos", le_x, 0);
    chk("line1_hsync_low_cycles", low_cnt, 384);
    chk("line1_hsync_fall_x", fall_x, 656);
    chk("line1_hsync_rise_x", rise_x, 752);
    chk("line1_activex_fall_x", ax_fall_x, 640);

    wait_x(100);
    #1 tif.ActiveVideo = XR'(320);
    wait_le(c1, lmin, lmax);
    chk("midchange_line_cycles", c1 - c0, 800 * P);
    #1 tif.ActiveVideo = XR'(640);
    wait_le(c2, lmin, lmax);
    chk("short_line_cycles", c2 - c1, 480 * P);
    chk("short_line_sync_first", lmin, 336);
    chk("short_line_sync_last", lmax, 431);

    wait_x(700);
    chk("pre_reset_hsync", tif.hsync, 0);
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk("sync_reset_xpos", tif.xposition, 0);
    chk("sync_reset_hsync", tif.hsync, 1);
    chk("sync_reset_LineEnd", tif.LineEnd, 0);
    #1 RESET = 1'b1;
    repeat (20) @(negedge CLK);

    for (int it = 0; it < 300; it++) begin
      int mode, dur;
      mode = $urandom_range(0, 9);
      dur  = $urandom_range(1, 200);
      #1;
      case (mode)
        0: set_seg(0, 0, 0, 0);
        1: if ($urandom_range(0, 1) == 1) set_seg(1, 0, 0, 0); else set_seg(0, 0, 1, 0);
        2: begin
          RESET = 1'b0;
          repeat ($urandom_range(1, 3)) @(negedge CLK);
          #1 RESET = 1'b1;
        end
        9: set_seg($urandom_range(200, 1023), $urandom_range(200, 1023),
                   $urandom_range(200, 1023), $urandom_range(200, 1023));
        default: set_seg($urandom_range(0, 60), $urandom_range(0, 60),
                         $urandom_range(0, 60), $urandom_range(0, 60));
      endcase
      repeat (dur) @(negedge CLK);
    end

    #1 set_seg(0, 0, 0, 0);
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    #1 RESET = 1'b1;
    bad_x = 0; bad_h = 0; bad_ax = 0; bad_le = 0; ticks = 0; last_tick = -1; bad_per = 0;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge CLK);
      if (tif.xposition != 0) bad_x++;
      if (tif.hsync != 1'b1) bad_h++;
      if (tif.ActiveX != 1'b0) bad_ax++;
      if (tif.LineEnd != 1'b0) bad_le++;
      if (tif.PixelTick) begin
        if (last_tick >= 0 && k - last_tick != 4) bad_per++;
        last_tick = k;
        ticks++;
      end
    end
    chk("degen_xpos_nonzero", bad_x, 0);
    chk("degen_hsync_low", bad_h, 0);
    chk("degen_activex_high", bad_ax, 0);
    chk("degen_lineend", bad_le, 0);
    chk("degen_tick_period", bad_per, 0);
    chk("degen_tick_count", ticks, 500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
